// File: rtl/video_dma_writer_pkg.sv
// Shared types and constants for the video DMA writer: FSM encoding, FIFO entry and word layout.
package video_dma_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_PAD     = 2'd3
  } vdw_state_e;

  localparam logic [7:0]  PIXEL_PAD_BYTE = 8'h00;
  localparam int unsigned WORD_W         = 64;
  localparam int unsigned ENTRY_W        = WORD_W + 1;

  // Byte offsets inside a packed 64-bit word: {pad, B1, G1, R1, pad, B0, G0, R0}
  localparam int unsigned R0_LSB   = 0;
  localparam int unsigned G0_LSB   = 8;
  localparam int unsigned B0_LSB   = 16;
  localparam int unsigned PAD0_LSB = 24;
  localparam int unsigned R1_LSB   = 32;
  localparam int unsigned G1_LSB   = 40;
  localparam int unsigned B1_LSB   = 48;
  localparam int unsigned PAD1_LSB = 56;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } vdw_entry_t;

  function automatic logic [WORD_W-1:0] pack_pixels(
    input logic [7:0] r0, input logic [7:0] g0, input logic [7:0] b0,
    input logic [7:0] r1, input logic [7:0] g1, input logic [7:0] b1
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[R0_LSB   +: 8] = r0;
    w[G0_LSB   +: 8] = g0;
    w[B0_LSB   +: 8] = b0;
    w[PAD0_LSB +: 8] = PIXEL_PAD_BYTE;
    w[R1_LSB   +: 8] = r1;
    w[G1_LSB   +: 8] = g1;
    w[B1_LSB   +: 8] = b1;
    w[PAD1_LSB +: 8] = PIXEL_PAD_BYTE;
    return w;
  endfunction

endpackage

// File: rtl/video_dma_writer_fifo.sv
// Single-clock show-ahead FIFO holding packed words plus their last tag.
module vdw_sync_fifo #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 65
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  // Head entry is presented directly; zero while empty so idle outputs read as zero.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/video_dma_writer.sv
// Captures 2PPC video frames into 64-bit words and streams them to a DMA write port.
// Optional internal test pattern when CAPTURE_TPG_EN is defined.
module video_dma_writer
  import video_dma_writer_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 480,
  parameter int unsigned FIFO_DEPTH   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture_en,
  input  logic        in_vs,
  input  logic        in_hs,
  input  logic        in_valid,
  input  logic [15:0] in_r,
  input  logic [15:0] in_g,
  input  logic [15:0] in_b,
  output logic [63:0] dma_wdata,
  output logic        dma_wvalid,
  output logic        dma_wlast,
  output logic [7:0]  dma_wkeep,
  input  logic        dma_wready,
  output logic [15:0] frame_cnt,
  output logic        dbg_overflow,
  output logic        dbg_short_frame,
  output logic [31:0] dbg_word_cnt
);

  localparam int unsigned WPL         = FRAME_WIDTH / 2;
  localparam int unsigned FRAME_WORDS = WPL * FRAME_HEIGHT;
  localparam int unsigned IDX_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  vdw_state_e        state, state_nx;
  logic [IDX_W-1:0]  word_idx, word_idx_nx;
  logic              vs_q;
  logic              frame_start;
  logic              vs_rise;
  logic              ovf_set;
  logic              short_set;
  logic              wr_en;
  vdw_entry_t        wr_entry;
  vdw_entry_t        rd_entry;
  logic [WORD_W-1:0] cap_word;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              unused_sig;

  assign frame_start = vs_q && !in_vs;
  assign vs_rise     = !vs_q && in_vs;
  assign accept      = dma_wvalid && dma_wready;

`ifdef CAPTURE_TPG_EN
  localparam int unsigned COL_W = (WPL > 1) ? $clog2(WPL) : 1;

  logic [COL_W-1:0] col_q, col_nx;
  logic [7:0]       tpg_x0;
  logic [7:0]       tpg_x1;

  assign tpg_x0     = 8'({col_q, 1'b0});
  assign tpg_x1     = 8'({col_q, 1'b1});
  assign cap_word   = pack_pixels(tpg_x0, tpg_x0, tpg_x0, tpg_x1, tpg_x1, tpg_x1);
  assign unused_sig = ^{in_hs, in_r, in_g, in_b};

  // Column counter tracks word_idx modulo words-per-line without a divider.
  always_comb begin
    col_nx = col_q;
    if (word_idx_nx == '0)
      col_nx = '0;
    else if (wr_en)
      col_nx = (col_q == COL_W'(WPL - 1)) ? '0 : col_q + COL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) col_q <= '0;
    else        col_q <= col_nx;
  end
`else
  assign cap_word   = pack_pixels(in_r[7:0], in_g[7:0], in_b[7:0],
                                  in_r[15:8], in_g[15:8], in_b[15:8]);
  assign unused_sig = in_hs;
`endif

  always_comb begin
    state_nx      = state;
    word_idx_nx   = word_idx;
    wr_en         = 1'b0;
    wr_entry.data = cap_word;
    wr_entry.last = 1'b0;
    ovf_set       = 1'b0;
    short_set     = 1'b0;
    case (state)
      ST_IDLE: begin
        word_idx_nx = '0;
        if (capture_en) state_nx = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        word_idx_nx = '0;
        if (!capture_en)
          state_nx = ST_IDLE;
        else if (frame_start && (fifo_count <= CW'(FIFO_DEPTH / 2)))
          state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (vs_rise) begin
          short_set = 1'b1;
          state_nx  = ST_PAD;
        end else if (in_valid) begin
          if (fifo_full) begin
            ovf_set = 1'b1;
          end else begin
            wr_en         = 1'b1;
            wr_entry.last = (word_idx == LAST_IDX);
            if (word_idx == LAST_IDX) begin
              word_idx_nx = '0;
              state_nx    = capture_en ? ST_WAIT_VS : ST_IDLE;
            end else begin
              word_idx_nx = word_idx + IDX_W'(1);
            end
          end
        end
      end
      ST_PAD: begin
        wr_entry.data = '0;
        if (!fifo_full) begin
          wr_en         = 1'b1;
          wr_entry.last = (word_idx == LAST_IDX);
          if (word_idx == LAST_IDX) begin
            word_idx_nx = '0;
            state_nx    = capture_en ? ST_WAIT_VS : ST_IDLE;
          end else begin
            word_idx_nx = word_idx + IDX_W'(1);
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      word_idx        <= '0;
      vs_q            <= 1'b0;
      dbg_overflow    <= 1'b0;
      dbg_short_frame <= 1'b0;
      frame_cnt       <= '0;
      dbg_word_cnt    <= '0;
    end else begin
      state           <= state_nx;
      word_idx        <= word_idx_nx;
      vs_q            <= in_vs;
      dbg_overflow    <= dbg_overflow | ovf_set;
      dbg_short_frame <= dbg_short_frame | short_set;
      if (accept) dbg_word_cnt <= dbg_word_cnt + 32'd1;
      if (accept && dma_wlast) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  vdw_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (dma_wready),
    .rd_data (rd_entry),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign dma_wvalid = !fifo_empty;
  assign dma_wdata  = rd_entry.data;
  assign dma_wlast  = rd_entry.last;
  assign dma_wkeep  = 8'hFF;

endmodule

// File: tb/tb_video_dma_writer.sv
// Scoreboard bench for video_dma_writer on an 8x2 frame with a 4-deep FIFO.
module tb_video_dma_writer;

  logic        clk;
  logic        rst_n;
  logic        capture_en;
  logic        in_vs, in_hs, in_valid;
  logic [15:0] in_r, in_g, in_b;
  logic [63:0] dma_wdata;
  logic        dma_wvalid, dma_wlast;
  logic [7:0]  dma_wkeep;
  logic        dma_wready;
  logic [15:0] frame_cnt;
  logic        dbg_overflow, dbg_short_frame;
  logic [31:0] dbg_word_cnt;

  video_dma_writer #(
    .FRAME_WIDTH  (8),
    .FRAME_HEIGHT (2),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .capture_en      (capture_en),
    .in_vs           (in_vs),
    .in_hs           (in_hs),
    .in_valid        (in_valid),
    .in_r            (in_r),
    .in_g            (in_g),
    .in_b            (in_b),
    .dma_wdata       (dma_wdata),
    .dma_wvalid      (dma_wvalid),
    .dma_wlast       (dma_wlast),
    .dma_wkeep       (dma_wkeep),
    .dma_wready      (dma_wready),
    .frame_cnt       (frame_cnt),
    .dbg_overflow    (dbg_overflow),
    .dbg_short_frame (dbg_short_frame),
    .dbg_word_cnt    (dbg_word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [64:0] sb [$];
  int          total = 0;
  int          bad   = 0;
  int          exp_words  = 0;
  int          exp_frames = 0;
  logic        toggle_rdy = 1'b0;
  logic        hold_v     = 1'b0;
  logic [64:0] hold_e     = '0;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (toggle_rdy) dma_wready = !dma_wready;
  endtask

  function automatic logic [7:0] chan(input int i, input int seed, input int k);
    return 8'(seed * 16 + 6 * i + k + 1);
  endfunction

  function automatic logic [63:0] exp_word(input int i, input int seed);
`ifdef CAPTURE_TPG_EN
    logic [7:0] x0, x1;
    x0 = 8'(2 * (i % 4));
    x1 = x0 + 8'd1;
    return {8'h00, x1, x1, x1, 8'h00, x0, x0, x0};
`else
    return {8'h00, chan(i, seed, 5), chan(i, seed, 4), chan(i, seed, 3),
            8'h00, chan(i, seed, 2), chan(i, seed, 1), chan(i, seed, 0)};
`endif
  endfunction

  task automatic push_exp(input logic last, input logic [63:0] w);
    sb.push_back({last, w});
    exp_words++;
    if (last) exp_frames++;
  endtask

  task automatic drive_beat(input int i, input int seed, input logic expect_it);
    in_valid = 1'b1;
    in_r = {chan(i, seed, 3), chan(i, seed, 0)};
    in_g = {chan(i, seed, 4), chan(i, seed, 1)};
    in_b = {chan(i, seed, 5), chan(i, seed, 2)};
    if (expect_it) push_exp(i == 7, exp_word(i, seed));
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic push_pad(input int from);
    for (int i = from; i < 8; i++) push_exp(i == 7, 64'h0);
  endtask

  task automatic frame_start();
    in_vs = 1'b1;
    cyc();
    cyc();
    in_vs = 1'b0;
    cyc();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      cyc();
      n++;
    end
    repeat (3) cyc();
    chk(tag, 65'(sb.size()), 65'd0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_frame_cnt"}, 65'(frame_cnt), 65'(exp_frames));
    chk({tag, "_word_cnt"}, 65'(dbg_word_cnt), 65'(exp_words));
  endtask

  // Pop/compare every accepted word; check that stalled words hold stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 65'(dma_wvalid), 65'd1);
        chk("hold_data", {dma_wlast, dma_wdata}, hold_e);
      end
      if (dma_wvalid && dma_wready) begin
        chk("sb_nonempty", 65'(sb.size() > 0), 65'd1);
        chk("wkeep", 65'(dma_wkeep), 65'hFF);
        if (sb.size() > 0) chk("word", {dma_wlast, dma_wdata}, sb.pop_front());
      end
      hold_v <= dma_wvalid && !dma_wready;
      hold_e <= {dma_wlast, dma_wdata};
    end
  end

  initial begin
    int lat;
    rst_n = 1'b0; capture_en = 1'b0; in_vs = 1'b0; in_hs = 1'b0; in_valid = 1'b0;
    in_r = '0; in_g = '0; in_b = '0; dma_wready = 1'b1;
    #1;
    chk("rst_wvalid", 65'(dma_wvalid), 65'd0);
    chk("rst_wlast", 65'(dma_wlast), 65'd0);
    chk("rst_wdata", 65'(dma_wdata), 65'd0);
    chk("rst_frame_cnt", 65'(frame_cnt), 65'd0);
    chk("rst_word_cnt", 65'(dbg_word_cnt), 65'd0);
    chk("rst_ovf", 65'(dbg_overflow), 65'd0);
    chk("rst_short", 65'(dbg_short_frame), 65'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    capture_en = 1'b1;
    cyc();

    // Nominal frame, with first-beat latency and pixel0 packing check
    frame_start();
    drive_beat(0, 0, 1'b1);
    lat = 0;
    while (!dma_wvalid && lat < 3) begin
      cyc();
      lat++;
    end
    chk("latency_valid", 65'(dma_wvalid), 65'd1);
`ifndef CAPTURE_TPG_EN
    chk("word0_low", 65'(dma_wdata[31:0]), 65'h00030201);
`endif
    for (int i = 1; i < 8; i++) drive_beat(i, 0, 1'b1);
    drain("nominal_drain");
    chk_counts("nominal");
    chk("nominal_ovf", 65'(dbg_overflow), 65'd0);

    // Backpressure: ready toggles every cycle, beats every other cycle
    toggle_rdy = 1'b1;
    frame_start();
    for (int i = 0; i < 8; i++) begin
      drive_beat(i, 1, 1'b1);
      cyc();
    end
    drain("bp_drain");
    toggle_rdy = 1'b0;
    dma_wready = 1'b1;
    chk_counts("bp");
    chk("bp_ovf", 65'(dbg_overflow), 65'd0);

    // Short frame: vs rises after 5 beats
    frame_start();
    for (int i = 0; i < 5; i++) drive_beat(i, 2, 1'b1);
    in_vs = 1'b1;
    push_pad(5);
    cyc();
    drain("short_drain");
    chk_counts("short");
    chk("short_flag", 65'(dbg_short_frame), 65'd1);

    // Reset mid-frame after 3 beats
    frame_start();
    for (int i = 0; i < 3; i++) drive_beat(i, 3, 1'b1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_words = 0;
    exp_frames = 0;
    chk("mrst_wvalid", 65'(dma_wvalid), 65'd0);
    chk("mrst_wlast", 65'(dma_wlast), 65'd0);
    chk("mrst_wdata", 65'(dma_wdata), 65'd0);
    chk("mrst_frame_cnt", 65'(frame_cnt), 65'd0);
    chk("mrst_word_cnt", 65'(dbg_word_cnt), 65'd0);
    chk("mrst_short", 65'(dbg_short_frame), 65'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    frame_start();
    for (int i = 0; i < 8; i++) drive_beat(i, 4, 1'b1);
    drain("post_rst_drain");
    chk_counts("post_rst");

    // Overflow: ready low, only 4 words fit, rest padded after vs rises
    dma_wready = 1'b0;
    frame_start();
    for (int i = 0; i < 8; i++) drive_beat(i, 5, i < 4);
    cyc();
    chk("ovf_flag", 65'(dbg_overflow), 65'd1);
    chk("ovf_wvalid", 65'(dma_wvalid), 65'd1);
    dma_wready = 1'b1;
    repeat (6) cyc();
    in_vs = 1'b1;
    push_pad(4);
    cyc();
    drain("ovf_drain");
    chk_counts("ovf");

    // Skip: FIFO left above half-full when the next frame starts
    frame_start();
    for (int i = 0; i < 8; i++) begin
      if (i == 5) dma_wready = 1'b0;
      drive_beat(i, 6, 1'b1);
    end
    frame_start();
    for (int i = 0; i < 8; i++) drive_beat(i, 7, 1'b0);
    dma_wready = 1'b1;
    drain("skip_drain");
    chk_counts("skip");
    frame_start();
    for (int i = 0; i < 8; i++) drive_beat(i, 8, 1'b1);
    drain("after_skip_drain");
    chk_counts("after_skip");

    // Disable mid-frame: frame completes, next frame produces nothing
    frame_start();
    for (int i = 0; i < 4; i++) drive_beat(i, 9, 1'b1);
    capture_en = 1'b0;
    for (int i = 4; i < 8; i++) drive_beat(i, 9, 1'b1);
    drain("dis_drain");
    chk_counts("dis");
    frame_start();
    for (int i = 0; i < 8; i++) drive_beat(i, 10, 1'b0);
    drain("idle_drain");
    chk_counts("idle");
    chk("idle_wvalid", 65'(dma_wvalid), 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
